// File: rtl/or_vector_seq.sv
// or_vector_seq: stimulus/check sequencer for a WIDTH-input OR gate.
// Walks vec_out through 0 .. 2**WIDTH-1. Each vector is held for SETTLE cycles,
// sampled for one cycle and then held for DWELL cycles. The sampled gate output
// is compared against the OR of the vector, and mismatches are counted in err_cnt.
// Optional build macro OR_SEQ_HALT_EN: stop the run at the first mismatch,
// leaving vec_out on the failing vector.
module or_vector_seq #(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 3,
  parameter int DWELL  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] vec_out,
  input  logic             gate_in,
  output logic             busy,
  output logic             sample_valid,
  output logic [WIDTH-1:0] sample_vec,
  output logic             sample_val,
  output logic [WIDTH:0]   err_cnt,
  output logic             done
);

  localparam int CNT_MAX = (SETTLE > DWELL) ? SETTLE : DWELL;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             mismatch;
  logic             settle_end;
  logic             hold_end;
  logic             last_vec;

  // An X/Z on the gate output is treated as a failure, not as a match.
  function automatic logic is_mismatch(input logic [WIDTH-1:0] v, input logic g);
    return (g !== (|v));
  endfunction

  assign mismatch   = is_mismatch(vec_out, gate_in);
  assign settle_end = (cnt_q == CNT_W'(SETTLE - 1));
  assign hold_end   = (cnt_q == CNT_W'(DWELL - 1));
  assign last_vec   = &vec_out;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and status decode
  always_comb begin
    state_d      = state_q;
    busy         = 1'b0;
    sample_valid = 1'b0;
    done         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        busy = 1'b1;
        if (settle_end) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        busy         = 1'b1;
        sample_valid = 1'b1;
`ifdef OR_SEQ_HALT_EN
        if (mismatch || last_vec) state_d = S_DONE;
        else                      state_d = S_HOLD;
`else
        if (last_vec) state_d = S_DONE;
        else          state_d = S_HOLD;
`endif
      end
      S_HOLD: begin
        busy = 1'b1;
        if (hold_end) state_d = S_SETTLE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sample_vec = vec_out;

  // Dwell counter: restarts on every state change, counts while a state is held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_d != state_q) begin
      cnt_q <= '0;
    end else if (state_q == S_SETTLE || state_q == S_HOLD) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Vector register: cleared on accepted start, stepped at end of each hold, never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_out <= '0;
    end else if (state_q == S_IDLE && start) begin
      vec_out <= '0;
    end else if (state_q == S_HOLD && hold_end) begin
      vec_out <= vec_out + 1'b1;
    end
  end

  // Mismatch counter: 2**WIDTH vectors always fit in WIDTH+1 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (state_q == S_IDLE && start) begin
      err_cnt <= '0;
    end else if (state_q == S_SAMPLE && mismatch) begin
      err_cnt <= err_cnt + (WIDTH+1)'(1);
    end
  end

  // Captured gate output, visible the cycle after SAMPLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_val <= 1'b0;
    end else if (state_q == S_SAMPLE) begin
      sample_val <= gate_in;
    end
  end

endmodule

// File: tb/tb_or_vector_seq.sv
// Testbench for or_vector_seq with default parameters. The gate under test is
// modelled by a selectable behaviour (OR, stuck-0, AND, inverted OR, random table).
// Expected timing and counts come from the per-vector period arithmetic.
module tb_or_vector_seq;

  localparam int W   = 2;
  localparam int ST  = 3;
  localparam int DW  = 16;
  localparam int PER = ST + 1 + DW;
  localparam int NV  = 1 << W;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] vec_out;
  logic         gate_in;
  logic         busy;
  logic         sample_valid;
  logic [W-1:0] sample_vec;
  logic         sample_val;
  logic [W:0]   err_cnt;
  logic         done;

  int   checks;
  int   errors;
  int   mode;
  logic rnd_tab [NV];

  or_vector_seq #(.WIDTH(W), .SETTLE(ST), .DWELL(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .vec_out      (vec_out),
    .gate_in      (gate_in),
    .busy         (busy),
    .sample_valid (sample_valid),
    .sample_vec   (sample_vec),
    .sample_val   (sample_val),
    .err_cnt      (err_cnt),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: correct OR, 1: stuck 0, 2: AND, 3: inverted OR, 4: random table
  function automatic logic gate_fn(input int m, input int k);
    case (m)
      0:       return logic'(k != 0);
      1:       return 1'b0;
      2:       return logic'(k == NV - 1);
      3:       return logic'(k == 0);
      default: return rnd_tab[k];
    endcase
  endfunction

  assign gate_in = gate_fn(mode, int'(vec_out));

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({vec_out, err_cnt, sample_val, busy, sample_valid, done} !== '0) begin
      errors++;
      $display("FAIL reset_state: got vec=%0d err=%0d val=%b busy=%b sv=%b done=%b, need all 0",
               vec_out, err_cnt, sample_val, busy, sample_valid, done);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL idle_no_start: busy=%b done=%b, need 0 0", busy, done);
    end
  endtask

  // One full run from the current negedge; repulse re-drives start at cycle 10
  // and at the done cycle, both of which must be ignored.
  task automatic run_check(input string name, input int m, input bit repulse);
    int   exp_err;
    int   last;
    int   done_cyc;
    int   k;
    bit   halted;
    logic g;
    logic [2:0] exp_flags;
    mode    = m;
    exp_err = 0;
    last    = NV - 1;
    halted  = 1'b0;
    for (int v = 0; v < NV; v++) begin
      g = gate_fn(m, v);
      if (!halted && g !== logic'(v != 0)) begin
        exp_err++;
`ifdef OR_SEQ_HALT_EN
        halted = 1'b1;
        last   = v;
`endif
      end
    end
    done_cyc = ST + 1 + PER * last + 1;

    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= done_cyc + 1; n++) begin
      if (n > 1) @(negedge clk);
      if (repulse) start = (n == 10 || n == done_cyc) ? 1'b1 : 1'b0;
      exp_flags[2] = (n < done_cyc);
      exp_flags[1] = (n >= ST + 1) && ((n - ST - 1) % PER == 0) && (n < done_cyc);
      exp_flags[0] = (n == done_cyc);
      checks++;
      if ({busy, sample_valid, done} !== exp_flags) begin
        errors++;
        $display("FAIL %s_flags cyc %0d: busy/sv/done=%b, need %b", name, n,
                 {busy, sample_valid, done}, exp_flags);
      end
      if (exp_flags[1]) begin
        k = (n - ST - 1) / PER;
        checks++;
        if (sample_vec !== W'(k)) begin
          errors++;
          $display("FAIL %s_sample_vec cyc %0d: got %0d, need %0d", name, n, sample_vec, k);
        end
      end
      if (n > ST + 1 && (n - ST - 2) % PER == 0 && n <= done_cyc) begin
        k = (n - ST - 2) / PER;
        checks++;
        if (sample_val !== gate_fn(m, k)) begin
          errors++;
          $display("FAIL %s_sample_val cyc %0d: got %b, need %b", name, n, sample_val, gate_fn(m, k));
        end
      end
      if (n >= done_cyc) begin
        checks++;
        if (err_cnt !== (W+1)'(exp_err) || vec_out !== W'(last)) begin
          errors++;
          $display("FAIL %s_result cyc %0d: err_cnt=%0d vec=%0d, need err_cnt=%0d vec=%0d",
                   name, n, err_cnt, vec_out, exp_err, last);
        end
      end
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_or_model();
    run_check("or_model", 0, 1'b0);
  endtask

  task automatic test_stuck0();
    run_check("stuck0", 1, 1'b0);
  endtask

  task automatic test_and_model();
    run_check("and_model", 2, 1'b0);
  endtask

  task automatic test_all_fail();
    run_check("inv_model", 3, 1'b0);
  endtask

  task automatic test_start_ignored();
    run_check("repulse", 1, 1'b1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      for (int v = 0; v < NV; v++) rnd_tab[v] = logic'($urandom_range(0, 1));
      run_check("random", 4, 1'b0);
    end
  endtask

  task automatic test_reset_midrun();
    mode  = 1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    checks++;
    if (err_cnt !== (W+1)'(1) || busy !== 1'b1 && err_cnt !== (W+1)'(1)) begin
      errors++;
      $display("FAIL midrun_before_reset: err_cnt=%0d busy=%b, need err_cnt=1", err_cnt, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({vec_out, busy, err_cnt, sample_valid, done} !== '0) begin
      errors++;
      $display("FAIL midrun_reset: vec=%0d busy=%b err=%0d sv=%b done=%b, need all 0",
               vec_out, busy, err_cnt, sample_valid, done);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b00) begin
        errors++;
        $display("FAIL midrun_held: busy=%b done=%b, need 0 0", busy, done);
      end
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_check("after_reset", 0, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mode   = 0;
    for (int v = 0; v < NV; v++) rnd_tab[v] = 1'b0;
    test_reset();
    test_or_model();
    test_stuck0();
    test_and_model();
    test_all_fail();
    test_start_ignored();
    test_reset_midrun();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
